// File: rtl/axis_spm_offset_slew.sv
// Per-channel slew-limited offset with optional sin/cos modulation on one channel,
// decimated update tick, and a three-stage saturating output pipeline.
module axis_spm_offset_slew #(
  parameter int NCH           = 4,
  parameter int DW            = 32,
  parameter int RDECI         = 5,
  parameter int SC_DATA_WIDTH = 25,
  parameter int SC_Q_WIDTH    = 24
) (
  input  logic              a_clk,
  input  logic              a_rst,
  input  logic [NCH*DW-1:0] S_AXIS_IN_tdata,
  input  logic              S_AXIS_IN_tvalid,
  input  logic [63:0]       S_AXIS_SC_tdata,
  input  logic              S_AXIS_SC_tvalid,
  input  logic [NCH*DW-1:0] offset_target,
  input  logic [DW-1:0]     offset_step,
  input  logic [31:0]       modulation_volume,
  input  logic [7:0]        modulation_target,
  input  logic              freeze,
  output logic [NCH*DW-1:0] M_AXIS_OUT_tdata,
  output logic              M_AXIS_OUT_tvalid,
  output logic [NCH*DW-1:0] M_AXIS_OFFMON_tdata,
  output logic              M_AXIS_OFFMON_tvalid,
  output logic [63:0]       M_AXIS_SC_tdata,
  output logic              M_AXIS_SC_tvalid,
  output logic [NCH-1:0]    settled
);

  localparam int PW = 2 * SC_DATA_WIDTH;
  localparam int CW = (RDECI > 0) ? RDECI : 1;
  localparam logic signed [DW+1:0] SAT_HI = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [DW+1:0] SAT_LO = -SAT_HI;

  typedef enum logic [1:0] {SLEWING, SETTLED, FROZEN} state_t;

  logic [CW-1:0]             cnt;
  logic                      tick;
  logic signed [DW-1:0]      tgt      [NCH];
  logic signed [DW-1:0]      in_ch    [NCH];
  logic signed [DW-1:0]      in_lat   [NCH];
  logic signed [DW-1:0]      off      [NCH];
  logic signed [DW-1:0]      off_nxt  [NCH];
  logic signed [DW:0]        diff     [NCH];
  logic signed [DW:0]        step_x;
  logic signed [DW+1:0]      mod_sel  [NCH];
  logic signed [DW+1:0]      sum_r    [NCH];
  logic signed [DW+1:0]      sat_v    [NCH];
  logic signed [DW-1:0]      out_r    [NCH];
  state_t                    state     [NCH];
  state_t                    state_nxt [NCH];
  logic signed [SC_DATA_WIDTH-1:0] mv;
  logic signed [SC_DATA_WIDTH-1:0] sn;
  logic signed [PW-1:0]      prod;
  logic signed [DW-1:0]      mod_nxt;
  logic signed [DW-1:0]      mod_r;
  logic                      s1_v;
  logic                      s2_v;
  logic                      out_v;
  logic                      unused_vol_bits;

  // With RDECI = 0 the counter is pinned at zero and every clock is a tick.
  always_ff @(posedge a_clk) begin
    if (a_rst || RDECI == 0) cnt <= '0;
    else                     cnt <= cnt + CW'(1);
  end
  assign tick = (RDECI == 0) || (cnt == '1);

  assign step_x  = $signed({1'b0, offset_step});
  assign mv      = modulation_volume[31 -: SC_DATA_WIDTH];
  assign sn      = S_AXIS_SC_tdata[32 +: SC_DATA_WIDTH];
  assign prod    = PW'(mv) * PW'(sn);
  assign mod_nxt = DW'(prod >>> SC_Q_WIDTH);
  assign unused_vol_bits = &{1'b0, modulation_volume[31-SC_DATA_WIDTH:0]};

  // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      tgt[i]   = offset_target[i*DW +: DW];
      in_ch[i] = S_AXIS_IN_tdata[i*DW +: DW];
      // One extra bit keeps target - cur exact, so a step can never wrap.
      diff[i]  = (DW+1)'(tgt[i]) - (DW+1)'(off[i]);
      if (diff[i] > step_x)       off_nxt[i] = DW'((DW+1)'(off[i]) + step_x);
      else if (diff[i] < -step_x) off_nxt[i] = DW'((DW+1)'(off[i]) - step_x);
      else                        off_nxt[i] = tgt[i];

      state_nxt[i] = state[i];
      if (tick) begin
        if (freeze)                 state_nxt[i] = FROZEN;
        else if (off_nxt[i] == tgt[i]) state_nxt[i] = SETTLED;
        else                        state_nxt[i] = SLEWING;
      end

      mod_sel[i] = (32'(modulation_target) == i + 1) ? (DW+2)'(mod_r) : '0;
      if (sum_r[i] > SAT_HI)      sat_v[i] = SAT_HI;
      else if (sum_r[i] < SAT_LO) sat_v[i] = SAT_LO;
      else                        sat_v[i] = sum_r[i];
    end
  end

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      for (int i = 0; i < NCH; i++) state[i] <= SLEWING;
    end else begin
      for (int i = 0; i < NCH; i++) state[i] <= state_nxt[i];
    end
  end

  // NOTE: the small per-channel arrays are cleared on reset so a slew in flight leaves no trace.
  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      for (int i = 0; i < NCH; i++) begin
        in_lat[i] <= '0;
        off[i]    <= '0;
        sum_r[i]  <= '0;
        out_r[i]  <= '0;
      end
      mod_r <= '0;
      s1_v  <= 1'b0;
      s2_v  <= 1'b0;
      out_v <= 1'b0;
    end else begin
      s1_v  <= tick;
      s2_v  <= s1_v;
      out_v <= s2_v;
      if (tick) begin
        mod_r <= mod_nxt;
        for (int i = 0; i < NCH; i++) begin
          if (S_AXIS_IN_tvalid) in_lat[i] <= in_ch[i];
          if (!freeze)          off[i]    <= off_nxt[i];
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (s1_v) sum_r[i] <= (DW+2)'(in_lat[i]) + (DW+2)'(off[i]) + mod_sel[i];
        if (s2_v) out_r[i] <= DW'(sat_v[i]);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      M_AXIS_OUT_tdata[i*DW +: DW]    = out_r[i];
      M_AXIS_OFFMON_tdata[i*DW +: DW] = off[i];
      settled[i]                      = (state[i] == SETTLED);
    end
  end

  assign M_AXIS_OUT_tvalid    = out_v;
  assign M_AXIS_OFFMON_tvalid = 1'b1;
  assign M_AXIS_SC_tdata      = S_AXIS_SC_tdata;
  assign M_AXIS_SC_tvalid     = S_AXIS_SC_tvalid;

endmodule

// File: tb/tb_axis_spm_offset_slew.sv
// Bench for axis_spm_offset_slew: directed scenarios plus randomized traffic against
// a tick-level arithmetic model; a second instance runs undecimated (RDECI = 0).
module tb_axis_spm_offset_slew;
  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int PER = 4;
  localparam longint MAXP = 64'sd2147483647;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [127:0]  in_d, tgt;
  logic          in_v, sc_v, frz;
  logic [63:0]   sc_d;
  logic [31:0]   step, vol;
  logic [7:0]    mt;
  logic [127:0]  out_d, mon_d, z_out_d, z_mon_d;
  logic          out_v, mon_v, sco_v, z_out_v, z_mon_v, z_sco_v;
  logic [63:0]   sco_d, z_sco_d;
  logic [3:0]    setl, z_setl;

  axis_spm_offset_slew #(.NCH(NCH), .DW(DW), .RDECI(2)) dut (
    .a_clk(clk), .a_rst(rst),
    .S_AXIS_IN_tdata(in_d), .S_AXIS_IN_tvalid(in_v),
    .S_AXIS_SC_tdata(sc_d), .S_AXIS_SC_tvalid(sc_v),
    .offset_target(tgt), .offset_step(step),
    .modulation_volume(vol), .modulation_target(mt), .freeze(frz),
    .M_AXIS_OUT_tdata(out_d), .M_AXIS_OUT_tvalid(out_v),
    .M_AXIS_OFFMON_tdata(mon_d), .M_AXIS_OFFMON_tvalid(mon_v),
    .M_AXIS_SC_tdata(sco_d), .M_AXIS_SC_tvalid(sco_v),
    .settled(setl));

  axis_spm_offset_slew #(.NCH(NCH), .DW(DW), .RDECI(0)) dut0 (
    .a_clk(clk), .a_rst(rst),
    .S_AXIS_IN_tdata(in_d), .S_AXIS_IN_tvalid(in_v),
    .S_AXIS_SC_tdata(sc_d), .S_AXIS_SC_tvalid(sc_v),
    .offset_target(tgt), .offset_step(step),
    .modulation_volume(vol), .modulation_target(mt), .freeze(frz),
    .M_AXIS_OUT_tdata(z_out_d), .M_AXIS_OUT_tvalid(z_out_v),
    .M_AXIS_OFFMON_tdata(z_mon_d), .M_AXIS_OFFMON_tvalid(z_mon_v),
    .M_AXIS_SC_tdata(z_sco_d), .M_AXIS_SC_tvalid(z_sco_v),
    .settled(z_setl));

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the RDECI=2 instance, advanced once per clock edge.
  int     n_edge, sum_at, out_at;
  longint m_cur [NCH], m_hold [NCH], m_out [NCH], pend [NCH];
  longint m_mod;
  bit     m_settled [NCH];
  bit     m_tvalid;

  function automatic longint sx32(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint sat(input longint v);
    if (v > MAXP)  return MAXP;
    if (v < -MAXP) return -MAXP;
    return v;
  endfunction

  function automatic longint slew(input longint cur, input longint target, input longint stp);
    longint d;
    d = target - cur;
    if (d > stp)  return cur + stp;
    if (d < -stp) return cur - stp;
    return target;
  endfunction

  function automatic longint mod_of(input logic [31:0] v, input logic [63:0] sc);
    longint a, s;
    a = longint'($signed(v)) >>> 7;
    s = longint'(sc[56:32]);
    if (s >= 64'sd16777216) s = s - 64'sd33554432;
    return (a * s) >>> 24;
  endfunction

  task automatic clk_edge();
    @(posedge clk);
    #1;
    if (rst) begin
      n_edge = 0; sum_at = -1; out_at = -1; m_mod = 0; m_tvalid = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_cur[i] = 0; m_hold[i] = 0; m_out[i] = 0; m_settled[i] = 1'b0;
      end
    end else begin
      n_edge++;
      m_tvalid = (n_edge == out_at);
      if (m_tvalid) for (int i = 0; i < NCH; i++) m_out[i] = pend[i];
      if (n_edge == sum_at) begin
        for (int i = 0; i < NCH; i++)
          pend[i] = sat(m_hold[i] + m_cur[i] + ((int'(mt) == i + 1) ? m_mod : 0));
        out_at = n_edge + 1;
      end
      if (n_edge % PER == 0) begin
        for (int i = 0; i < NCH; i++) begin
          if (in_v) m_hold[i] = sx32(in_d[i*32 +: 32]);
          if (!frz) m_cur[i] = slew(m_cur[i], sx32(tgt[i*32 +: 32]), longint'(step));
          m_settled[i] = !frz && (m_cur[i] == sx32(tgt[i*32 +: 32]));
        end
        m_mod  = mod_of(vol, sc_d);
        sum_at = n_edge + 1;
      end
    end
  endtask

  task automatic wait_tick();
    for (int k = 0; k < PER; k++) begin
      clk_edge();
      if (n_edge % PER == 0) return;
    end
  endtask

  task automatic idle_inputs();
    in_d = '0; in_v = 1'b0; tgt = '0; step = '0; vol = '0; mt = '0; frz = 1'b0;
    sc_d = {$urandom, $urandom}; sc_v = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk_edge();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    n_checks++; if (mon_d !== '0)   begin n_fail++; $display("FAIL reset_offmon got %h want 0", mon_d); end
    n_checks++; if (out_d !== '0)   begin n_fail++; $display("FAIL reset_out got %h want 0", out_d); end
    n_checks++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b want 0", out_v); end
    n_checks++; if (setl !== 4'h0)  begin n_fail++; $display("FAIL reset_settled got %b want 0000", setl); end
    n_checks++; if (mon_v !== 1'b1) begin n_fail++; $display("FAIL offmon_tvalid got %b want 1", mon_v); end
    n_checks++; if (sco_d !== sc_d || sco_v !== sc_v)
      begin n_fail++; $display("FAIL sc_passthru got %h/%b want %h/%b", sco_d, sco_v, sc_d, sc_v); end
    sc_d = {$urandom, $urandom}; sc_v = 1'b0; #1;
    n_checks++; if (z_sco_d !== sc_d || z_sco_v !== 1'b0)
      begin n_fail++; $display("FAIL sc_passthru_comb got %h/%b want %h/0", z_sco_d, z_sco_v, sc_d); end
    for (int k = 1; k < PER; k++) begin
      clk_edge();
      n_checks++; if (setl !== 4'h0) begin n_fail++; $display("FAIL pre_tick_settled edge %0d got %b want 0000", k, setl); end
    end
  endtask

  task automatic test_slew();
    longint exp_off [4] = '{100, 200, 300, 350};
    idle_inputs();
    do_reset();
    tgt[31:0] = 32'd350; step = 32'd100;
    for (int t = 0; t < 4; t++) begin
      wait_tick();
      n_checks++; if (sx32(mon_d[31:0]) !== exp_off[t])
        begin n_fail++; $display("FAIL slew_off tick %0d got %0d want %0d", t + 1, sx32(mon_d[31:0]), exp_off[t]); end
      n_checks++; if (setl !== {3'b111, (t == 3) ? 1'b1 : 1'b0})
        begin n_fail++; $display("FAIL slew_settled tick %0d got %b", t + 1, setl); end
    end
  endtask

  task automatic test_wrap();
    idle_inputs();
    do_reset();
    tgt[31:0] = 32'h80000001; step = 32'h7FFFFFFF;
    wait_tick();
    n_checks++; if (mon_d[31:0] !== 32'h80000001) begin n_fail++; $display("FAIL wrap_init got %h want 80000001", mon_d[31:0]); end
    tgt[31:0] = 32'h7FFFFFFF;
    wait_tick();
    n_checks++; if (mon_d[31:0] !== 32'h00000000) begin n_fail++; $display("FAIL wrap_tick1 got %h want 00000000", mon_d[31:0]); end
    wait_tick();
    n_checks++; if (mon_d[31:0] !== 32'h7FFFFFFF || setl[0] !== 1'b1)
      begin n_fail++; $display("FAIL wrap_tick2 got %h/%b want 7fffffff/1", mon_d[31:0], setl[0]); end
  endtask

  task automatic test_saturation();
    idle_inputs();
    do_reset();
    tgt[31:0] = 32'h00001000; tgt[63:32] = 32'hFFFFFFFB; step = 32'h7FFFFFFF;
    in_d[31:0] = 32'h7FFFFF00; in_d[63:32] = 32'h80000001; in_v = 1'b1;
    wait_tick();
    clk_edge();
    n_checks++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL sat_tvalid_t1 got %b want 0", out_v); end
    clk_edge();
    n_checks++; if (out_v !== 1'b1) begin n_fail++; $display("FAIL sat_tvalid_t2 got %b want 1", out_v); end
    n_checks++; if (out_d !== {64'h0, 32'h80000001, 32'h7FFFFFFF})
      begin n_fail++; $display("FAIL sat_out got %h want 80000001_7fffffff in low words", out_d); end
    clk_edge();
    n_checks++; if (out_v !== 1'b0 || out_d[31:0] !== 32'h7FFFFFFF)
      begin n_fail++; $display("FAIL sat_pulse got %b/%h want 0/7fffffff", out_v, out_d[31:0]); end
  endtask

  task automatic test_modulation();
    logic [31:0] base [NCH];
    idle_inputs();
    do_reset();
    for (int i = 0; i < NCH; i++) begin
      base[i] = 32'($urandom_range(0, 2000000)) - 32'd1000000;
      in_d[i*32 +: 32] = base[i];
    end
    in_v = 1'b1; vol = 32'h7FFFFFFF; sc_d = {7'h0, 25'h0FFFFFF, $urandom}; mt = 8'd2;
    wait_tick(); clk_edge(); clk_edge();
    for (int i = 0; i < NCH; i++) begin
      n_checks++; if (out_d[i*32 +: 32] !== base[i] + ((i == 1) ? 32'd16777214 : 32'd0))
        begin n_fail++; $display("FAIL mod_ch%0d got %h base %h", i, out_d[i*32 +: 32], base[i]); end
    end
    mt = 8'd5;
    wait_tick(); clk_edge(); clk_edge();
    n_checks++; if (out_d[63:32] !== base[1]) begin n_fail++; $display("FAIL mod_none got %h want %h", out_d[63:32], base[1]); end
  endtask

  task automatic test_freeze();
    idle_inputs();
    do_reset();
    tgt[31:0] = 32'd1000; step = 32'd100;
    wait_tick(); wait_tick();
    n_checks++; if (mon_d[31:0] !== 32'd200) begin n_fail++; $display("FAIL frz_pre got %0d want 200", mon_d[31:0]); end
    frz = 1'b1;
    for (int t = 0; t < 2; t++) begin
      wait_tick();
      n_checks++; if (mon_d[31:0] !== 32'd200 || setl !== 4'h0)
        begin n_fail++; $display("FAIL frz_hold got %0d/%b want 200/0000", mon_d[31:0], setl); end
    end
    frz = 1'b0;
    wait_tick();
    n_checks++; if (mon_d[31:0] !== 32'd300 || setl !== 4'hE)
      begin n_fail++; $display("FAIL frz_resume got %0d/%b want 300/1110", mon_d[31:0], setl); end
  endtask

  task automatic test_reset_midslew();
    idle_inputs();
    do_reset();
    tgt[31:0] = 32'd5000; step = 32'd100; in_d = {4{32'd7}}; in_v = 1'b1;
    for (int t = 0; t < 10; t++) wait_tick();
    n_checks++; if (mon_d[31:0] !== 32'd1000) begin n_fail++; $display("FAIL mid_pre got %0d want 1000", mon_d[31:0]); end
    do_reset();
    n_checks++; if (mon_d !== '0 || out_d !== '0 || out_v !== 1'b0 || setl !== 4'h0)
      begin n_fail++; $display("FAIL mid_reset got %h/%h/%b/%b want zeros", mon_d[31:0], out_d[31:0], out_v, setl); end
    for (int k = 1; k < PER; k++) begin
      clk_edge();
      n_checks++; if (mon_d !== '0 || out_v !== 1'b0)
        begin n_fail++; $display("FAIL mid_quiet edge %0d got %h/%b", k, mon_d[31:0], out_v); end
    end
    clk_edge();
    n_checks++; if (mon_d[31:0] !== 32'd100) begin n_fail++; $display("FAIL mid_first_tick got %0d want 100", mon_d[31:0]); end
  endtask

  task automatic test_random();
    for (int e = 0; e < 1200; e++) begin
      if ($urandom_range(0, 3) == 0) in_d = {$urandom, $urandom, $urandom, $urandom};
      in_v = $urandom_range(0, 1);
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 15) == 0)
          tgt[i*32 +: 32] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 4000)) - 32'd2000;
      case ($urandom_range(0, 15))
        0: step = '0;
        1: step = $urandom;
        2, 3, 4: step = 32'($urandom_range(1, 500));
        default: ;
      endcase
      vol  = $urandom; sc_d = {$urandom, $urandom}; sc_v = $urandom_range(0, 1);
      mt   = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 31) == 0) frz = ~frz;
      clk_edge();
      for (int i = 0; i < NCH; i++) begin
        n_checks++; if (sx32(mon_d[i*32 +: 32]) !== m_cur[i])
          begin n_fail++; $display("FAIL rnd_off e%0d ch%0d got %h want %h", e, i, mon_d[i*32 +: 32], 32'(m_cur[i])); end
        n_checks++; if (setl[i] !== m_settled[i])
          begin n_fail++; $display("FAIL rnd_settled e%0d ch%0d got %b want %b", e, i, setl[i], m_settled[i]); end
        n_checks++; if (sx32(out_d[i*32 +: 32]) !== m_out[i])
          begin n_fail++; $display("FAIL rnd_out e%0d ch%0d got %h want %h", e, i, out_d[i*32 +: 32], 32'(m_out[i])); end
      end
      n_checks++; if (out_v !== m_tvalid) begin n_fail++; $display("FAIL rnd_tvalid e%0d got %b want %b", e, out_v, m_tvalid); end
    end
    frz = 1'b0;
  endtask

  task automatic test_rdeci0();
    longint exp_q [$];
    longint t [NCH];
    longint want;
    idle_inputs();
    do_reset();
    step = 32'h7FFFFFFF; in_v = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      t[i] = longint'($urandom_range(0, 32'h3FFFFFFF)) - 64'sd536870912;
      tgt[i*32 +: 32] = 32'(t[i]);
    end
    for (int k = 0; k < 12; k++) begin
      in_d = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < NCH; i++) exp_q.push_back(sat(sx32(in_d[i*32 +: 32]) + t[i]));
      clk_edge();
      n_checks++; if (z_mon_v !== 1'b1 || z_setl !== 4'hF || z_mon_d !== tgt)
        begin n_fail++; $display("FAIL z_offmon k%0d got %h/%b want %h", k, z_mon_d, z_setl, tgt); end
      if (k >= 2) begin
        n_checks++; if (z_out_v !== 1'b1) begin n_fail++; $display("FAIL z_tvalid k%0d got %b want 1", k, z_out_v); end
        for (int i = 0; i < NCH; i++) begin
          want = exp_q.pop_front();
          n_checks++; if (sx32(z_out_d[i*32 +: 32]) !== want)
            begin n_fail++; $display("FAIL z_out k%0d ch%0d got %h want %h", k, i, z_out_d[i*32 +: 32], 32'(want)); end
        end
      end else begin
        n_checks++; if (z_out_v !== 1'b0) begin n_fail++; $display("FAIL z_fill k%0d got %b want 0", k, z_out_v); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_slew();
    test_wrap();
    test_saturation();
    test_modulation();
    test_freeze();
    test_reset_midslew();
    test_random();
    test_rdeci0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
